// File: rtl/oam_dma_ctrl_if.sv
// rtl/oam_dma_ctrl_if.sv - CPU-side and memory-side bus bundle for the sprite DMA controller
interface oam_dma_ctrl_if;
   // CPU side
   logic [15:0] cpu_addr_out;
   logic [7:0]  cpu_data_out;
   logic        cpu_ren;
   logic        cpu_wen;
   logic [7:0]  cpu_data_in;
   logic        cpu_rdy;
   // memory-map side
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_out;
   logic        mem_ren;
   logic        mem_wen;
   logic [7:0]  mem_data_in;
   // status
   logic        dma_busy;
   logic        dma_done;

   // controller view
   modport master (
      input  cpu_addr_out, cpu_data_out, cpu_ren, cpu_wen, mem_data_in,
      output cpu_data_in, cpu_rdy, mem_addr, mem_data_out, mem_ren, mem_wen,
             dma_busy, dma_done
   );

   // CPU + memory-map view
   modport slave (
      output cpu_addr_out, cpu_data_out, cpu_ren, cpu_wen, mem_data_in,
      input  cpu_data_in, cpu_rdy, mem_addr, mem_data_out, mem_ren, mem_wen,
             dma_busy, dma_done
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA sequencer and CPU/memory bus arbiter
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int          XFER_LEN      = 256
) (
   input  logic              clk,
   input  logic              rst,
   oam_dma_ctrl_if.master    bus
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] latch_q, latch_d;
   logic       parity_q, parity_d;
   logic       cpu_rdy_q, cpu_rdy_d;
   logic       dma_busy_q, dma_busy_d;
   logic       dma_done_q, dma_done_d;

   logic       passthru;
   logic       trigger;

   // DONE behaves exactly like IDLE on the bus, including accepting a retrigger
   assign passthru = (state_q == S_IDLE) || (state_q == S_DONE);
   assign trigger  = passthru && bus.cpu_wen && (bus.cpu_addr_out == DMA_REG_ADDR);

   // next-state and registered-output computation
   always_comb begin
      state_d    = state_q;
      page_d     = page_q;
      idx_d      = idx_q;
      latch_d    = latch_q;
      parity_d   = ~parity_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (trigger) begin
               page_d  = bus.cpu_data_out;
               idx_d   = 8'h00;
               state_d = S_HALT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
         S_ALIGN: state_d = S_READ;
         S_READ: begin
            latch_d = bus.mem_data_in;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // status outputs are registered, so derive them from the state being entered
      cpu_rdy_d  = (state_d == S_IDLE) || (state_d == S_DONE);
      dma_busy_d = (state_d == S_HALT) || (state_d == S_ALIGN) ||
                   (state_d == S_READ) || (state_d == S_WRITE);
      dma_done_d = (state_d == S_DONE);
   end

   // state register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         page_q     <= 8'h00;
         idx_q      <= 8'h00;
         latch_q    <= 8'h00;
         parity_q   <= 1'b0;
         cpu_rdy_q  <= 1'b1;
         dma_busy_q <= 1'b0;
         dma_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         idx_q      <= idx_d;
         latch_q    <= latch_d;
         parity_q   <= parity_d;
         cpu_rdy_q  <= cpu_rdy_d;
         dma_busy_q <= dma_busy_d;
         dma_done_q <= dma_done_d;
      end
   end

   // bus mux: CPU passthrough when idle, DMA drive during transfer, silent in reset
   always_comb begin
      bus.mem_addr     = 16'h0000;
      bus.mem_data_out = 8'h00;
      bus.mem_ren      = 1'b0;
      bus.mem_wen      = 1'b0;
      bus.cpu_data_in  = 8'h00;
      if (!rst) begin
         if (passthru) begin
            bus.mem_addr     = bus.cpu_addr_out;
            bus.mem_data_out = bus.cpu_data_out;
            bus.mem_ren      = bus.cpu_ren;
            bus.mem_wen      = bus.cpu_wen;
            bus.cpu_data_in  = bus.mem_data_in;
         end else if (state_q == S_READ) begin
            // idx never carries into the page byte
            bus.mem_addr = {page_q, idx_q};
            bus.mem_ren  = 1'b1;
         end else if (state_q == S_WRITE) begin
            bus.mem_addr     = OAM_DATA_ADDR;
            bus.mem_data_out = latch_q;
            bus.mem_wen      = 1'b1;
         end
      end
   end

   assign bus.cpu_rdy  = cpu_rdy_q;
   assign bus.dma_busy = dma_busy_q;
   assign bus.dma_done = dma_done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - randomized self-checking bench for oam_dma_ctrl
module tb_oam_dma_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   oam_dma_ctrl_if bus();

   oam_dma_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // memory map model: combinational read, write on the clock edge
   logic [7:0] mem [0:65535];
   assign bus.mem_data_in = bus.mem_ren ? mem[bus.mem_addr] : 8'h00;
   always @(posedge clk) if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_data_out;

   // edges since reset release; its LSB is the parity the controller sees
   int cyc_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc_cnt <= 0;
      else     cyc_cnt <= cyc_cnt + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // bus monitor, sampled on the falling edge
   int          ncyc = 0;
   int          stall_cnt, done_cnt, halt_cyc, first_ren, bad_cnt;
   int          oam_wr_total = 0;
   logic [15:0] rd_q[$];
   logic [7:0]  wr_q[$];

   always @(negedge clk) begin
      ncyc++;
      if (!bus.cpu_rdy) stall_cnt++;
      if (bus.dma_done) done_cnt++;
      if (bus.dma_busy && halt_cyc < 0) halt_cyc = ncyc;
      if (bus.dma_busy && bus.mem_ren) begin
         if (first_ren < 0) first_ren = ncyc;
         rd_q.push_back(bus.mem_addr);
      end
      if (bus.dma_busy && bus.mem_wen && bus.mem_addr == 16'h2004) wr_q.push_back(bus.mem_data_out);
      if (bus.mem_wen && bus.mem_addr == 16'h2004) oam_wr_total++;
      if (!bus.cpu_rdy && ((bus.cpu_data_in != 8'h00) ||
          ((bus.mem_ren || bus.mem_wen) && bus.mem_addr[15:8] == 8'h00))) bad_cnt++;
   end

   task automatic cpu_idle();
      bus.cpu_ren = 1'b0; bus.cpu_wen = 1'b0;
      bus.cpu_addr_out = 16'h0000; bus.cpu_data_out = 8'h00;
   endtask

   // write the DMA register so that the HALT cycle sees the requested parity
   task automatic trigger(input logic [7:0] page, input int want_par);
      while (((cyc_cnt + 1) % 2) != want_par) begin
         @(posedge clk); #1;
      end
      bus.cpu_wen = 1'b1; bus.cpu_addr_out = 16'h4014; bus.cpu_data_out = page;
      @(negedge clk);
      chk("trig_fwd_wen",  32'(bus.mem_wen), 32'd1);
      chk("trig_fwd_addr", 32'(bus.mem_addr), 32'h4014);
      chk("trig_fwd_data", 32'(bus.mem_data_out), 32'(page));
      chk("trig_rdy",      32'(bus.cpu_rdy), 32'd1);
      @(posedge clk); #1;
   endtask

   // called just after the trigger edge; hold: 0 none, 1 held read of 0x0001, 2 held retrigger to page 3
   task automatic xfer_check(input string tag, input logic [7:0] page, input int hold);
      logic [7:0] exp_d [0:255];
      int         par;
      bit         seen;
      for (int i = 0; i < 256; i++) exp_d[i] = mem[{page, 8'(i)}];
      par = cyc_cnt % 2;
      stall_cnt = 0; done_cnt = 0; halt_cyc = -1; first_ren = -1; bad_cnt = 0;
      rd_q.delete(); wr_q.delete();
      cpu_idle();
      if (hold == 1) begin
         bus.cpu_ren = 1'b1; bus.cpu_addr_out = 16'h0001;
      end else if (hold == 2) begin
         bus.cpu_wen = 1'b1; bus.cpu_addr_out = 16'h4014; bus.cpu_data_out = 8'h03;
      end
      seen = 0;
      for (int c = 0; c < 700 && !seen; c++) begin
         @(negedge clk);
         if (bus.dma_done) seen = 1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (!seen) begin
         cpu_idle();
         return;
      end
      chk({tag, "_done_rdy"}, 32'(bus.cpu_rdy), 32'd1);
      chk({tag, "_done_busy"}, 32'(bus.dma_busy), 32'd0);
      if (hold == 1) chk({tag, "_held_read"}, 32'(bus.cpu_data_in), 32'(mem[16'h0001]));
      if (hold == 2) begin
         chk({tag, "_retrig_wen"}, 32'(bus.mem_wen), 32'd1);
         chk({tag, "_retrig_addr"}, 32'(bus.mem_addr), 32'h4014);
      end
      @(posedge clk); #1;
      cpu_idle();
      chk({tag, "_stall"}, 32'(stall_cnt), 32'(513 + par));
      chk({tag, "_first_ren"}, 32'(first_ren - halt_cyc), 32'(1 + par));
      chk({tag, "_ndone"}, 32'(done_cnt), 32'd1);
      chk({tag, "_bad_bus"}, 32'(bad_cnt), 32'd0);
      chk({tag, "_nwr"}, 32'(wr_q.size()), 32'd256);
      chk({tag, "_nrd"}, 32'(rd_q.size()), 32'd256);
      if (wr_q.size() == 256 && rd_q.size() == 256) begin
         for (int i = 0; i < 256; i++) begin
            chk({tag, "_wr_data"}, 32'(wr_q[i]), 32'(exp_d[i]));
            chk({tag, "_rd_addr"}, 32'(rd_q[i]), 32'({page, 8'(i)}));
         end
      end
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  d, pg;
      bit          r;
      int          nw, base_wr, base_done;
      bit          hit;

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0001] = 8'hA5;

      // reset state, with a CPU read pending to show outputs are forced low
      rst = 1'b1;
      cpu_idle();
      bus.cpu_ren = 1'b1; bus.cpu_addr_out = 16'h0001;
      repeat (2) @(negedge clk);
      chk("rst_rdy",   32'(bus.cpu_rdy), 32'd1);
      chk("rst_busy",  32'(bus.dma_busy), 32'd0);
      chk("rst_done",  32'(bus.dma_done), 32'd0);
      chk("rst_ren",   32'(bus.mem_ren), 32'd0);
      chk("rst_addr",  32'(bus.mem_addr), 32'd0);
      chk("rst_cpudi", 32'(bus.cpu_data_in), 32'd0);
      @(posedge clk); #1;
      cpu_idle();
      rst = 1'b0;

      // idle passthrough: fixed sequence then random traffic, none may trigger
      for (int k = 0; k < 13; k++) begin
         if (k == 0)      begin r = 1; a = 16'h0001; d = 8'h00; end
         else if (k == 1) begin r = 0; a = 16'h4015; d = 8'($urandom); end
         else if (k == 2) begin r = 1; a = 16'h4014; d = 8'h00; end
         else begin
            r = 1'($urandom); a = 16'h6000 + 16'($urandom_range(0, 16'h1FFF)); d = 8'($urandom);
         end
         bus.cpu_ren = r; bus.cpu_wen = !r; bus.cpu_addr_out = a; bus.cpu_data_out = d;
         @(negedge clk);
         chk("idle_addr", 32'(bus.mem_addr), 32'(a));
         chk("idle_ren",  32'(bus.mem_ren), 32'(r));
         chk("idle_wen",  32'(bus.mem_wen), 32'(!r));
         chk("idle_wdat", 32'(bus.mem_data_out), 32'(d));
         chk("idle_rdat", 32'(bus.cpu_data_in), r ? 32'(mem[a]) : 32'd0);
         chk("idle_rdy",  32'(bus.cpu_rdy), 32'd1);
         @(posedge clk); #1;
         cpu_idle();
      end
      repeat (3) @(negedge clk);
      chk("idle_nobusy", 32'(bus.dma_busy), 32'd0);
      chk("idle_rdy_end", 32'(bus.cpu_rdy), 32'd1);
      @(posedge clk); #1;

      // even-aligned transfer with a held CPU read
      trigger(8'h02, 0);
      xfer_check("even", 8'h02, 1);
      // odd-aligned transfer of the same page
      trigger(8'h02, 1);
      xfer_check("odd", 8'h02, 0);
      // top page wraps within itself
      trigger(8'hFF, int'($urandom_range(0, 1)));
      xfer_check("pageff", 8'hFF, 0);
      // retrigger during DONE
      trigger(8'h02, 0);
      xfer_check("retrig_a", 8'h02, 2);
      xfer_check("retrig_b", 8'h03, 0);
      // random pages (0x20 avoided: it overlaps the OAM data port)
      for (int k = 0; k < 3; k++) begin
         do pg = 8'($urandom); while (pg == 8'h20);
         trigger(pg, int'($urandom_range(0, 1)));
         xfer_check("rand", pg, int'($urandom_range(0, 1)));
      end

      // reset during the WRITE of idx 100
      trigger(8'h02, 0);
      nw = 0; hit = 0;
      for (int c = 0; c < 700 && !hit; c++) begin
         @(negedge clk);
         if (bus.mem_wen && bus.mem_addr == 16'h2004) begin
            if (nw == 100) hit = 1;
            else nw++;
         end
      end
      chk("rst_mid_reached", 32'(hit), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_rdy",  32'(bus.cpu_rdy), 32'd1);
      chk("rst_mid_busy", 32'(bus.dma_busy), 32'd0);
      chk("rst_mid_wen",  32'(bus.mem_wen), 32'd0);
      @(posedge clk); #1;
      base_wr = oam_wr_total; base_done = done_cnt;
      rst = 1'b0;
      bus.cpu_ren = 1'b1; bus.cpu_addr_out = 16'h0001;
      @(negedge clk);
      chk("post_rst_ren",  32'(bus.mem_ren), 32'd1);
      chk("post_rst_addr", 32'(bus.mem_addr), 32'h0001);
      chk("post_rst_data", 32'(bus.cpu_data_in), 32'(mem[16'h0001]));
      chk("post_rst_rdy",  32'(bus.cpu_rdy), 32'd1);
      @(posedge clk); #1;
      cpu_idle();
      repeat (20) @(negedge clk);
      chk("post_rst_nowr",   32'(oam_wr_total - base_wr), 32'd0);
      chk("post_rst_nodone", 32'(done_cnt - base_done), 32'd0);
      chk("post_rst_busy",   32'(bus.dma_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
